johnson_phase_monitor: RTL
==========================

# johnson_phase_monitor

Downstream consumer of the N-bit Johnson ring counter in the counters library. Samples the counter's code, decodes it to a phase index, checks that every step is the legal successor, and tracks lock status with a saturating error count. Used wherever a multi-phase sequence drives later logic and code corruption must be detected.

## Interface

- N, 4: Johnson counter width; legal N >= 2; the sequence has 2N phases.
- LOCK_LEN, 4: consecutive good steps required to declare lock; legal 1..255.
- PW, $clog2(2*N): phase width (localparam).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset; one clock domain.
- en  in  1  sample enable; state updates only on cycles with en=1.
- q_in  in  N  Johnson code from the upstream counter.
- clr_err  in  1  synchronous clear of err_cnt; acts regardless of en.
- phase  out  PW  decoded phase index of the last sample.
- legal  out  1  last sample was a legal Johnson code.
- locked  out  1  FSM is in LOCKED.
- step_err  out  1  one-cycle pulse: sequence fault detected while LOCKED.
- wrap  out  1  one-cycle pulse: good step from phase 2N-1 to phase 0.
- err_cnt  out  8  saturating count of step_err events.

## Operation

- Upstream sequence (shift right, complement LSB into MSB): 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, then wrap.
- Decoding: k leading ones from the MSB with the rest zero gives phase k (k = 0..N). k trailing ones at the LSB with the MSB zero gives phase 2N-k (k = 1..N-1). Any other code is illegal; phase is then 0 and legal is 0.
- Step classification (en=1, previous sample legal):
  - good: new phase = (prev+1) mod 2N.
  - hold: new phase = prev. Not an error, not a good step.
  - bad: anything else.
- prev updates on every en=1 sample.
- FSM states are UNLOCK, ACQ and LOCKED. Good-step counter gcnt is 8 bits.
  - UNLOCK: legal sample -> ACQ, gcnt=0. Illegal sample -> stay.
  - ACQ: good step -> gcnt+1; on reaching LOCK_LEN -> LOCKED. Hold -> stay, gcnt unchanged. Legal bad step -> stay, gcnt=0. Illegal sample -> UNLOCK. No step_err and no err_cnt change in ACQ.
  - LOCKED: good step or hold -> stay. Legal bad step -> ACQ with gcnt=0, plus step_err. Illegal sample -> UNLOCK, plus step_err.
- err_cnt increments on each step_err and saturates at 255. If clr_err and an increment fall in the same cycle, clear wins and err_cnt=0.
- wrap pulses on a good step 2N-1 -> 0 in ACQ or LOCKED. It does not pulse in UNLOCK.
- en=0: phase, legal, prev, FSM and gcnt hold; step_err=0 and wrap=0.

## Timing

- All outputs are registered. A sample taken at rising edge t appears on phase, legal, locked, step_err and wrap immediately after edge t. This is one cycle of latency relative to q_in being set up before edge t.
- step_err and wrap are high for exactly one cycle per event.
- Reset (rst=0, asynchronous) forces immediately: phase=0, legal=0, locked=0, step_err=0, wrap=0, err_cnt=0, FSM=UNLOCK, gcnt=0, prev=0.
- Reset asserted mid-lock drops locked immediately with no step_err.
- After release, the first en=1 edge is the first sample. No fault is reported on the first sample.
- With a continuously advancing counter, en=1 and legal codes, lock takes 1 + LOCK_LEN sampled edges. locked goes high after the (LOCK_LEN+1)th en=1 edge.

## Test plan

- Reset release with en=1, driven by the N=4 counter sequence starting at 0000: phase reads 0,1,2,...,7,0. locked rises after the 5th edge. wrap pulses on each 7->0 step. err_cnt stays 0.
- While locked, inject 1010 for one cycle: legal=0, phase=0, locked=0, step_err=1 for one cycle, err_cnt=1. The FSM re-locks 5 edges after legal codes resume.
- While locked, jump 1100 -> 1111 (phase 2 -> 4): step_err=1, locked=0, legal stays 1, err_cnt increments. Re-lock follows 4 further good steps.
- Hold q_in at 1110 for 3 cycles with en=1, then toggle en=0 for 3 cycles while q_in changes arbitrarily: no step_err, no wrap, locked stays 1, and phase stays 3 throughout.
- Force 300 lock/fault cycles: err_cnt saturates at 255. Assert clr_err in the same cycle as a fault: err_cnt=0.
- Assert rst low asynchronously between edges while locked with err_cnt=5: all outputs go to 0 before the next edge. After release the FSM resumes from UNLOCK.

Source files
------------

// File: rtl/johnson_phase_monitor.sv
// johnson_phase_monitor
//
// Watches the code of an N-bit Johnson ring counter and reports whether
// it is stepping through its 2N-phase sequence correctly.
// The monitor does the following for each sample:
//   - decodes the code to a phase index,
//   - classifies the step from the previous sample as good, hold or bad,
//   - tracks lock with an UNLOCK / ACQ / LOCKED state machine,
//   - counts faults seen while locked in a saturating 8-bit counter.
//
// Parameters
//   N         Johnson counter width (>= 2); the sequence has 2N phases.
//   LOCK_LEN  consecutive good steps needed to declare lock (1..255).
//   PW        phase index width, $clog2(2*N).
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   en        sample enable; state only advances when en=1
//   q_in      Johnson code from the upstream counter
//   clr_err   synchronous clear of err_cnt, independent of en
//   phase     decoded phase of the last sample (0 when illegal)
//   legal     last sample was a legal Johnson code
//   locked    monitor is in LOCKED
//   step_err  one-cycle pulse on a sequence fault while LOCKED
//   wrap      one-cycle pulse on a good step 2N-1 -> 0 (ACQ or LOCKED)
//   err_cnt   saturating count of step_err events
module johnson_phase_monitor #(
    parameter int N        = 4,
    parameter int LOCK_LEN = 4,
    localparam int PW      = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  q_in,
    input  logic          clr_err,
    output logic [PW-1:0] phase,
    output logic          legal,
    output logic          locked,
    output logic          step_err,
    output logic          wrap,
    output logic [7:0]    err_cnt
);

    localparam logic [1:0] UNLOCK = 2'd0;
    localparam logic [1:0] ACQ    = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [PW-1:0] LAST_PHASE = PW'(2 * N - 1);
    localparam logic [7:0]    LOCK_CNT   = 8'(LOCK_LEN);

    // Returns {legal, phase}. Leading-ones codes map to phases 0..N,
    // trailing-ones codes (MSB clear) map to phases N+1..2N-1.
    function automatic logic [PW:0] decode(input logic [N-1:0] code);
        logic [PW:0]  res;
        logic [N-1:0] pat;
        res = '0;
        for (int k = 0; k <= N; k++) begin
            pat = '0;
            for (int b = 0; b < k; b++) pat[N-1-b] = 1'b1;
            if (code == pat) res = {1'b1, PW'(k)};
        end
        for (int k = 1; k < N; k++) begin
            pat = '0;
            for (int b = 0; b < k; b++) pat[b] = 1'b1;
            if (code == pat) res = {1'b1, PW'(2 * N - k)};
        end
        return res;
    endfunction

    logic [1:0]    state, state_n;
    logic [7:0]    gcnt, gcnt_n;
    logic [PW:0]   dec;
    logic          d_legal;
    logic [PW-1:0] d_phase;
    logic [PW-1:0] succ;
    logic          good, hold;
    logic          serr_n, wrap_n;
    logic [7:0]    err_n;

    // The phase register doubles as the previous sample: it updates on
    // every en=1 sample, and in ACQ/LOCKED the previous sample was legal.
    always_comb begin
        dec     = decode(q_in);
        d_legal = dec[PW];
        d_phase = dec[PW-1:0];
        succ    = (phase == LAST_PHASE) ? '0 : phase + 1'b1;
        good    = d_legal && (d_phase == succ);
        hold    = d_legal && (d_phase == phase);
    end

    always_comb begin
        state_n = state;
        gcnt_n  = gcnt;
        serr_n  = 1'b0;
        wrap_n  = 1'b0;
        if (en) begin
            case (state)
                UNLOCK: begin
                    if (d_legal) begin
                        state_n = ACQ;
                        gcnt_n  = '0;
                    end
                end
                ACQ: begin
                    if (!d_legal) begin
                        state_n = UNLOCK;
                        gcnt_n  = '0;
                    end else if (good) begin
                        wrap_n = (phase == LAST_PHASE);
                        if (gcnt + 8'd1 == LOCK_CNT) begin
                            state_n = LOCKED;
                            gcnt_n  = '0;
                        end else begin
                            gcnt_n = gcnt + 8'd1;
                        end
                    end else if (!hold) begin
                        gcnt_n = '0;
                    end
                end
                LOCKED: begin
                    if (!d_legal) begin
                        state_n = UNLOCK;
                        serr_n  = 1'b1;
                    end else if (good) begin
                        wrap_n = (phase == LAST_PHASE);
                    end else if (!hold) begin
                        state_n = ACQ;
                        gcnt_n  = '0;
                        serr_n  = 1'b1;
                    end
                end
                default: begin
                    state_n = UNLOCK;
                    gcnt_n  = '0;
                end
            endcase
        end
    end

    // Clear dominates a coincident increment; the count sticks at 255.
    always_comb begin
        err_n = err_cnt;
        if (clr_err) begin
            err_n = '0;
        end else if (serr_n && (err_cnt != 8'hFF)) begin
            err_n = err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= UNLOCK;
            gcnt     <= '0;
            phase    <= '0;
            legal    <= 1'b0;
            locked   <= 1'b0;
            step_err <= 1'b0;
            wrap     <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state    <= state_n;
            gcnt     <= gcnt_n;
            locked   <= (state_n == LOCKED);
            step_err <= serr_n;
            wrap     <= wrap_n;
            err_cnt  <= err_n;
            if (en) begin
                phase <= d_phase;
                legal <= d_legal;
            end
        end
    end

endmodule
